// File: rtl/buf_stripe_credit_rx.sv
// Receive-side stripe buffer: holds up to CREDIT_NUM stripes, forwards beats and returns one credit per drained stripe.
// Optional STRIPE_CUT_THROUGH_EN presents beats as soon as written; default build is store-and-forward.
module buf_stripe_credit_rx #(
    parameter int DATA_W       = 256,
    parameter int CREDIT_NUM   = 2,
    parameter int STRIPE_BEATS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_last,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_last,
    output logic                          credit_vld,
    output logic [$clog2(CREDIT_NUM):0]   stripe_cnt,
    output logic                          ovf_err
);

    localparam int DEPTH = CREDIT_NUM * STRIPE_BEATS;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(CREDIT_NUM) + 1;

    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DATA_W:0] mem [DEPTH];
    logic [AW:0]     wp;
    logic [AW:0]     rp;
    logic            full;
    logic            empty;
    logic            wr_fire;
    logic            rd_fire;
    logic            stripe_in;
    logic            stripe_out;
    logic            credit_vld_p1;

    // Extra wrap bit distinguishes full from empty when addresses coincide.
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = (wp == rp);

    assign in_rdy     = ~full;
    assign wr_fire    = in_vld & ~full;
    assign rd_fire    = out_vld & out_rdy;
    assign stripe_in  = wr_fire & in_last;
    assign stripe_out = rd_fire & out_last;

`ifdef STRIPE_CUT_THROUGH_EN
    assign out_vld = ~empty;
`else
    // A partial stripe stays hidden until its closing beat has been counted.
    assign out_vld = ~empty & (stripe_cnt != '0);
`endif

    assign {out_last, out_data} = mem[rp[AW-1:0]];
    assign credit_vld           = credit_vld_p1;

    // Storage: payload is not reset, only the pointers that qualify it.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wp[AW-1:0]] <= {in_last, in_data};
        end
    end

    // Control: pointers, stripe count, credit return and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp            <= '0;
            rp            <= '0;
            stripe_cnt    <= '0;
            credit_vld_p1 <= 1'b0;
            ovf_err       <= 1'b0;
        end else begin
            if (wr_fire) begin
                wp <= wp + PTR_ONE;
            end
            if (rd_fire) begin
                rp <= rp + PTR_ONE;
            end
            case ({stripe_in, stripe_out})
                2'b10:   stripe_cnt <= stripe_cnt + CNT_ONE;
                2'b01:   stripe_cnt <= stripe_cnt - CNT_ONE;
                default: stripe_cnt <= stripe_cnt;
            endcase
            credit_vld_p1 <= stripe_out;
            if (in_vld & full) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule
